// File: rtl/fetch_ifid.sv
// -----------------------------------------------------------------------------
// fetch_ifid
//
// Instruction-fetch stage plus the IF/ID pipeline register.
//
// The block owns the fetch PC and runs a req/ack handshake with instruction
// memory, which may insert any number of wait states. A stall from the hazard
// unit freezes the IF/ID register. A word that arrives during a stall is parked
// in a one-entry skid buffer, and no new request is issued while that buffer is
// full. Taken branches redirect fetch. If a request is already in flight when
// the branch arrives, the block waits for it in S_DROP, throws its data away,
// and then jumps to the target.
//
// Ports
//   clk             in   clock, rising edge
//   rst             in   asynchronous active-high reset
//   StallIn         in   hold the IF/ID register
//   FlushIn         in   replace IF/ID with a bubble
//   BranchTakenIn   in   redirect fetch and bubble IF/ID
//   BranchTargetIn  in   [31:0] redirect address, bits [1:0] ignored
//   ImemReqOut      out  fetch request
//   ImemAddrOut     out  [31:0] fetch byte address
//   ImemAckIn       in   data valid for the current request (1-cycle pulse)
//   ImemDataIn      in   [31:0] instruction word, sampled with ImemAckIn
//   InsOut          out  [31:0] IF/ID instruction; opcode is InsOut[4:0]
//   PCOut           out  [31:0] IF/ID PC of InsOut
//   PCPlus4Out      out  [31:0] PCOut + 4 (mod 2^32)
//   ValidOut        out  InsOut holds a real instruction
// -----------------------------------------------------------------------------
module fetch_ifid #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INS  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallIn,
    input  logic        FlushIn,
    input  logic        BranchTakenIn,
    input  logic [31:0] BranchTargetIn,
    output logic        ImemReqOut,
    output logic [31:0] ImemAddrOut,
    input  logic        ImemAckIn,
    input  logic [31:0] ImemDataIn,
    output logic [31:0] InsOut,
    output logic [31:0] PCOut,
    output logic [31:0] PCPlus4Out,
    output logic        ValidOut
);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_DROP = 1'b1
    } state_t;

    // Fetch-side state
    state_t      state_q,       state_d;
    logic [31:0] fetch_pc_q,    fetch_pc_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        req_q,         req_d;

    // Skid buffer
    logic        skid_valid_q,  skid_valid_d;
    logic [31:0] skid_ins_q,    skid_ins_d;
    logic [31:0] skid_pc_q,     skid_pc_d;

    // IF/ID register
    logic [31:0] ins_q,         ins_d;
    logic [31:0] pc_q,          pc_d;
    logic [31:0] pc4_q,         pc4_d;
    logic        valid_q,       valid_d;

    logic        ack_s;
    logic        ack_req_s;
    logic [31:0] target_s;
    logic        unused_target_s;

    // An ack only counts while a request is actually on the bus. This is what
    // makes a late ack arriving just after reset harmless.
    assign ack_s     = ImemAckIn & req_q;
    // Only an ack taken in S_REQ carries a word that may be kept.
    assign ack_req_s = ack_s & (state_q == S_REQ);
    assign target_s  = {BranchTargetIn[31:2], 2'b00};
    assign unused_target_s = ^BranchTargetIn[1:0];

    // State register: every flop of the block, with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_REQ;
            fetch_pc_q    <= RESET_PC;
            redirect_pc_q <= RESET_PC;
            req_q         <= 1'b0;
            skid_valid_q  <= 1'b0;
            skid_ins_q    <= NOP_INS;
            skid_pc_q     <= 32'h0000_0000;
            ins_q         <= NOP_INS;
            pc_q          <= 32'h0000_0000;
            pc4_q         <= 32'h0000_0004;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            redirect_pc_q <= redirect_pc_d;
            req_q         <= req_d;
            skid_valid_q  <= skid_valid_d;
            skid_ins_q    <= skid_ins_d;
            skid_pc_q     <= skid_pc_d;
            ins_q         <= ins_d;
            pc_q          <= pc_d;
            pc4_q         <= pc4_d;
            valid_q       <= valid_d;
        end
    end

    // Next-state logic. Priority is branch > flush > stall > normal.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        redirect_pc_d = redirect_pc_q;
        skid_valid_d  = skid_valid_q;
        skid_ins_d    = skid_ins_q;
        skid_pc_d     = skid_pc_q;
        ins_d         = ins_q;
        pc_d          = pc_q;
        pc4_d         = pc4_q;
        valid_d       = valid_q;

        if (BranchTakenIn) begin
            ins_d        = NOP_INS;
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
            // Jump now if the bus is idle or the in-flight request completes
            // this cycle. Otherwise the address must stay stable, so park the
            // target and drain the outstanding request in S_DROP.
            if (!req_q || ack_s) begin
                fetch_pc_d = target_s;
                state_d    = S_REQ;
            end else begin
                redirect_pc_d = target_s;
                state_d       = S_DROP;
            end
        end else begin
            // Fetch side. Stall and flush do not affect fetch progress.
            case (state_q)
                S_REQ: begin
                    if (ack_s) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end else begin
                        fetch_pc_d = fetch_pc_q;
                    end
                end
                S_DROP: begin
                    if (ack_s) begin
                        fetch_pc_d = redirect_pc_q;
                        state_d    = S_REQ;
                    end else begin
                        state_d    = S_DROP;
                    end
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase

            // IF/ID and skid side
            if (FlushIn) begin
                ins_d        = NOP_INS;
                valid_d      = 1'b0;
                skid_valid_d = 1'b0;
            end else if (StallIn) begin
                if (ack_req_s && !skid_valid_q) begin
                    skid_ins_d   = ImemDataIn;
                    skid_pc_d    = fetch_pc_q;
                    skid_valid_d = 1'b1;
                end else begin
                    skid_valid_d = skid_valid_q;
                end
            end else if (skid_valid_q) begin
                ins_d        = skid_ins_q;
                pc_d         = skid_pc_q;
                pc4_d        = skid_pc_q + 32'd4;
                valid_d      = 1'b1;
                skid_valid_d = 1'b0;
            end else if (ack_req_s) begin
                ins_d   = ImemDataIn;
                pc_d    = fetch_pc_q;
                pc4_d   = fetch_pc_q + 32'd4;
                valid_d = 1'b1;
            end else begin
                // Bubble: the PC fields keep their last value.
                ins_d   = NOP_INS;
                valid_d = 1'b0;
            end
        end
    end

    // Output logic. The request is registered from the next state so that it
    // is low during reset and first rises one cycle after reset is released.
    always_comb begin
        req_d = 1'b0;
        case (state_d)
            S_REQ:   req_d = !skid_valid_d;
            S_DROP:  req_d = 1'b1;
            default: req_d = 1'b0;
        endcase
    end

    assign ImemReqOut  = req_q;
    assign ImemAddrOut = fetch_pc_q;
    assign InsOut      = ins_q;
    assign PCOut       = pc_q;
    assign PCPlus4Out  = pc4_q;
    assign ValidOut    = valid_q;

endmodule

// File: doc/fetch_ifid.md
Name: fetch_ifid

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the basic pipeline.
- Owns the fetch PC and runs a req/ack handshake with instruction memory (variable wait states).
- Absorbs stalls in a one-entry skid buffer; handles branch redirects and flushes.
- Drives InsOut, the instruction word consumed by immediate generation and decode; opcode is InsOut[4:0].

Parameters:
- RESET_PC, 32'h00000000, fetch address after reset.
- NOP_INS, 32'h00000000, bubble instruction (opcode 5'h00, decodes as no-op with zero immediate).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- StallIn  in  1  hazard unit: hold the IF/ID register.
- FlushIn  in  1  replace the IF/ID contents with a bubble.
- BranchTakenIn  in  1  redirect fetch; also bubbles IF/ID.
- BranchTargetIn  in  32  redirect address; bits [1:0] are ignored (forced to 0).
- ImemReqOut  out  1  fetch request.
- ImemAddrOut  out  32  fetch byte address; stable while ImemReqOut=1 and ack not yet seen.
- ImemAckIn  in  1  data valid for the current request, one-cycle pulse.
- ImemDataIn  in  32  instruction word, sampled when ImemAckIn=1.
- InsOut  out  32  IF/ID instruction to immediate generation and decode.
- PCOut  out  32  IF/ID PC of InsOut.
- PCPlus4Out  out  32  PCOut+4, modulo 2^32.
- ValidOut  out  1  InsOut holds a real instruction.

Behaviour:
- Reset, asynchronous, applies immediately:
  - FetchPC=RESET_PC; state=S_REQ; SkidValid=0.
  - ImemReqOut=0; InsOut=NOP_INS; PCOut=0; PCPlus4Out=4; ValidOut=0.
  - ImemReqOut rises in the first cycle after rst deasserts.
- ImemAddrOut = FetchPC.
- ImemReqOut=1 when in S_REQ and SkidValid=0, or when in S_DROP. Once raised, ImemReqOut and ImemAddrOut stay unchanged until the ack cycle.
- Per-edge priority: rst > BranchTakenIn > FlushIn > StallIn > normal.
- Normal (no stall, flush or branch):
  - If SkidValid=1: IF/ID <= skid entry; SkidValid<=0.
  - Else if ack in S_REQ: IF/ID <= {ImemDataIn, FetchPC}; ValidOut<=1; FetchPC<=FetchPC+4.
  - Else: IF/ID <= bubble (InsOut=NOP_INS, ValidOut=0, PCOut unchanged).
  - Minimum latency: ack in cycle N gives InsOut valid in cycle N+1. Back-to-back acks give one instruction per cycle.
- StallIn=1:
  - IF/ID holds all outputs.
  - Ack in S_REQ with SkidValid=0: {data, FetchPC} goes into the skid buffer; SkidValid<=1; FetchPC+=4.
  - No new request is issued while SkidValid=1. With StallIn=1 and no ack, the request stays pending.
- FlushIn=1 (no branch):
  - IF/ID <= bubble.
  - Skid entry, if any, is discarded.
  - An ack in the same cycle is discarded, but FetchPC still advances by 4. The fetch stream is unchanged; only the IF/ID contents are lost.
- BranchTakenIn=1:
  - IF/ID <= bubble; SkidValid<=0.
  - If no request is outstanding, or the ack arrives this cycle: FetchPC<={BranchTargetIn[31:2],2'b00}; stay in S_REQ; ack data discarded.
  - If a request is outstanding with no ack: latch the target into RedirectPC and go to S_DROP.
- S_DROP:
  - Request stays on the old address. The ack data is discarded and is never written to IF/ID or the skid buffer.
  - On ack: FetchPC<=RedirectPC; state=S_REQ.
  - A further BranchTakenIn in S_DROP overwrites RedirectPC.
  - Stall and flush do not affect S_DROP progress.
- Wrap-around: FetchPC 32'hFFFFFFFC + 4 = 0; PCPlus4Out wraps the same way.
- Reset mid-request: state is dropped immediately; a late ack after reset, while ImemReqOut=0, is ignored.

Test Plan:
- Reset then zero-wait memory acking every cycle with data=addr|0x3 -> InsOut sequence 0x03, 0x07, 0x0B; PCOut 0, 4, 8; ValidOut=1 from the 2nd cycle after reset release.
- Memory with 3 wait states -> ImemAddrOut stable through the wait; InsOut=NOP_INS with ValidOut=0 for 3 cycles, then one valid instruction.
- StallIn held 4 cycles, ack lands in stall cycle 2 -> outputs frozen; ImemReqOut=0 after capture; on release, the skid word appears next cycle with its correct PC; no instruction lost or duplicated.
- BranchTakenIn with target 0x103 while a request to 0x20 is pending 2 more cycles -> ImemAddrOut stays 0x20 until ack; that data is never seen on InsOut; next address is 0x100.
- BranchTakenIn coincident with ack -> data dropped; next ImemAddrOut = target; ValidOut=0 next cycle.
- FlushIn together with StallIn and a full skid -> InsOut=NOP_INS, ValidOut=0; skid cleared; fetch continues at the following PC. Also force FetchPC=0xFFFFFFFC -> next PC=0, PCPlus4Out=0.
